// File: rtl/cmp_iter_pkg.sv
// Shared encodings for the iterative branch comparator: condition codes,
// result levels, FSM states and the condition-to-result mapping.
package cmp_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [2:0] CMP_OP_EQ  = 3'b000;
  localparam logic [2:0] CMP_OP_NE  = 3'b001;
  localparam logic [2:0] CMP_OP_LT  = 3'b100;
  localparam logic [2:0] CMP_OP_GE  = 3'b101;
  localparam logic [2:0] CMP_OP_LTU = 3'b110;
  localparam logic [2:0] CMP_OP_GEU = 3'b111;

  localparam logic CMP_TRUE  = 1'b1;
  localparam logic CMP_FALSE = 1'b0;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == CMP_OP_LT) || (op == CMP_OP_GE);
  endfunction

  // Reserved codes 010/011 fall through to CMP_FALSE.
  function automatic logic cmp_result(input logic [2:0] op, input logic eq,
                                      input logic lt);
    case (op)
      CMP_OP_EQ:              return eq;
      CMP_OP_NE:              return ~eq;
      CMP_OP_LT, CMP_OP_LTU:  return lt;
      CMP_OP_GE, CMP_OP_GEU:  return ~lt;
      default:                return CMP_FALSE;
    endcase
  endfunction

endpackage

// File: rtl/cmp_iter_if.sv
// Request/result handshake between a pipeline stage and the iterative comparator.
interface cmp_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] arg0;
  logic [WIDTH-1:0] arg1;
  logic [2:0]       op;
  logic             ready;
  logic             done;
  logic             true;

  modport master (output start, flush, arg0, arg1, op,
                  input  ready, done, true);
  modport slave  (input  start, flush, arg0, arg1, op,
                  output ready, done, true);
endinterface

// File: rtl/cmp_iter_slice.sv
// Combinational SLICE-bit compare; signed_msb_i flips the top bit so the
// unsigned magnitude compare orders two's-complement values.
module cmp_iter_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             signed_msb_i,
  output logic             eq_o,
  output logic             lt_o
);

  logic [SLICE-1:0] flip;

  always_comb begin
    flip            = '0;
    flip[SLICE-1]   = signed_msb_i;
  end

  assign eq_o = (a_i == b_i);
  assign lt_o = ((a_i ^ flip) < (b_i ^ flip));

endmodule

// File: rtl/cmp_iter.sv
// Iterative branch comparator: walks the operands MSB slice first and
// stops at the first differing slice.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// BUSY  | comparing slice idx, ready=0
// DONE  | result valid for one cycle, ready=1 (may accept next start)
module cmp_iter
  import cmp_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  cmp_iter_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             true_q, true_d;

  logic sl_eq, sl_lt, sl_signed;

  // Operands shift left each BUSY step, so the active slice is always on top.
  assign sl_signed = op_is_signed(op_q) && (idx_q == '0);

  cmp_iter_slice #(.SLICE(SLICE)) u_slice (
    .a_i          (a_q[WIDTH-1 -: SLICE]),
    .b_i          (b_q[WIDTH-1 -: SLICE]),
    .signed_msb_i (sl_signed),
    .eq_o         (sl_eq),
    .lt_o         (sl_lt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      true_q  <= CMP_FALSE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      true_q  <= true_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    true_d  = true_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d = ST_BUSY;
          idx_d   = '0;
          a_d     = bus.arg0;
          b_d     = bus.arg1;
          op_d    = bus.op;
        end
      end

      ST_BUSY: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (!sl_eq) begin
          state_d = ST_DONE;
          true_d  = cmp_result(op_q, 1'b0, sl_lt);
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          true_d  = cmp_result(op_q, 1'b1, 1'b0);
        end else begin
          idx_d   = idx_q + IDXW'(1);
          a_d     = a_q << SLICE;
          b_d     = b_q << SLICE;
        end
      end

      ST_DONE: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (bus.start) begin
          state_d = ST_BUSY;
          idx_d   = '0;
          a_d     = bus.arg0;
          b_d     = bus.arg1;
          op_d    = bus.op;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.true  = true_q;

endmodule

// File: tb/tb_cmp_iter.sv
// Scenario bench for cmp_iter (WIDTH=32, SLICE=8): expected result and latency
// are queued at accept and compared when done pulses.
module tb_cmp_iter;

  localparam logic [2:0] EQ  = 3'b000;
  localparam logic [2:0] NE  = 3'b001;
  localparam logic [2:0] LT  = 3'b100;
  localparam logic [2:0] GE  = 3'b101;
  localparam logic [2:0] LTU = 3'b110;
  localparam logic [2:0] GEU = 3'b111;
  localparam int MAXWAIT = 20;

  typedef struct {
    logic t;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic last_true = 1'b0;
  exp_t exp_q[$];

  cmp_iter_if #(.WIDTH(32)) bus ();

  cmp_iter #(.WIDTH(32), .SLICE(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    bit   found = 0;
    e.lat = 4;
    for (int k = 0; k < 4; k++) begin
      if (!found && (a[31-8*k -: 8] != b[31-8*k -: 8])) begin
        e.lat = k + 1;
        found = 1;
      end
    end
    case (op)
      EQ:      e.t = (a == b);
      NE:      e.t = (a != b);
      LT:      e.t = ($signed(a) < $signed(b));
      GE:      e.t = ($signed(a) >= $signed(b));
      LTU:     e.t = (a < b);
      GEU:     e.t = (a >= b);
      default: e.t = 1'b0;
    endcase
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input bit push);
    bus.start = 1'b1;
    bus.op    = op;
    bus.arg0  = a;
    bus.arg1  = b;
    @(posedge clk);
    if (push) exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.arg0  = ~a;
    bus.arg1  = $urandom;
    bus.op    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_result(input string name, input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (bus.done !== 1'b1 && n < MAXWAIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= MAXWAIT) begin
      errors++;
      $display("FAIL %s timeout: got no done within %0d cycles, required a done", name, n);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got done with empty scoreboard, required no done", name);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (n !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d, required %0d", name, n, e.lat);
    end
    checks++;
    if (bus.true !== e.t) begin
      errors++;
      $display("FAIL %s true: got %b, required %b", name, bus.true, e.t);
    end
    last_true = e.t;
  endtask

  task automatic run(input string name, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    drive_start(op, a, b, 1);
    wait_result(name, 0);
    @(negedge clk);
  endtask

  task automatic check_idle(input string name, input logic t_req);
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.true !== t_req) begin
      errors++;
      $display("FAIL %s: got ready=%b done=%b true=%b, required ready=1 done=0 true=%b",
               name, bus.ready, bus.done, bus.true, t_req);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.flush = 1'b0;
    bus.op    = EQ;
    bus.arg0  = 32'h0001_0000;
    bus.arg1  = 32'h0001_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset_hold", 1'b0);
    reset_n   = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check_idle("reset_no_accept", 1'b0);
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL reset_done_count: got %0d, required 0", done_cnt);
    end
    run("reset_eq", EQ, 32'h0001_0000, 32'h0001_0000);
  endtask

  task automatic test_early_exit();
    run("lt_msb", LT, 32'h8000_0000, 32'h0000_0001);
    run("ltu_msb", LTU, 32'h8000_0000, 32'h0000_0001);
    run("geu_ff", GEU, 32'hFFFF_FFFF, 32'h0000_0000);
    run("ge_ff", GE, 32'hFFFF_FFFF, 32'h0000_0000);
  endtask

  task automatic test_lower_slice();
    run("lt_low", LT, 32'h8000_0000, 32'h8000_0001);
    run("ne_top", NE, 32'h0000_1056, 32'h1056_1056);
    run("ge_mid", GE, 32'h1234_8000, 32'h1234_7FFF);
    run("ltu_slice2", LTU, 32'h00AA_0100, 32'h00AA_FF00);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    drive_start(LT, 32'h8000_0000, 32'h0000_0001, 1);
    wait_result("b2b_first", 0);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_in_done: got %b, required 1", bus.ready);
    end
    drive_start(GEU, 32'h0000_00FF, 32'h0000_0100, 1);
    wait_result("b2b_second", 0);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0);
    end

    d0 = done_cnt;
    drive_start(EQ, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    bus.start = 1'b1;
    bus.op    = LT;
    bus.arg0  = 32'h0000_0000;
    bus.arg1  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_result("busy_start", 1);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL busy_start_done_count: got %0d, required 1", done_cnt - d0);
    end
    run("reserved_011", 3'b011, 32'h0000_0001, 32'h0000_0002);
  endtask

  task automatic test_flush();
    int d0;
    run("pre_flush", LTU, 32'h8000_0000, 32'h0000_0001);
    d0 = done_cnt;
    drive_start(EQ, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 0);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_idle("flush_busy", last_true);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || bus.true !== last_true) begin
      errors++;
      $display("FAIL flush_no_done: got done_cnt delta=%0d true=%b, required 0 and %b",
               done_cnt - d0, bus.true, last_true);
    end
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = NE;
    bus.arg0  = 32'h1;
    bus.arg1  = 32'h2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check_idle("flush_start_idle", last_true);
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL flush_start_no_done: got delta %0d, required 0", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    run("pre_reset", GEU, 32'hFFFF_FFFF, 32'h0000_0000);
    drive_start(EQ, 32'h1111_2222, 32'h1111_2222, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_idle("reset_mid", 1'b0);
    run("post_reset", LT, 32'h0000_0005, 32'h0000_0007);
  endtask

  initial begin
    test_reset();
    test_early_exit();
    test_lower_slice();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
